obc_dft_sequencer: RTL and testbench

Bit-serial controller for the offset-binary-coded (OBC) distributed-arithmetic DFT output stage. It latches one frame of 16 two's-complement samples and presents one bit-slice per cycle, MSB first, to the external combinational OBC ROM accumulator, together with the sign-select bit `m`. It Horner-accumulates the 32-bit ROM sums into a wide result, adds the OBC offset constant, and returns the result through a valid/ready handshake. One instance sits in front of each ROM-accumulator bank, giving one DFT output term per frame.

---
 rtl/obc_dft_sequencer.sv | 128 ++++++++++++
 tb/tb_obc_dft_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obc_dft_sequencer.sv
// Bit-serial sequencer for an OBC distributed-arithmetic DFT term: streams MSB-first
// bit-slices of 16 latched samples to an external ROM and Horner-accumulates its sums.
module obc_dft_sequencer #(
    parameter int W  = 16,
    parameter int AW = 32 + W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            start_rdy,
    input  logic [16*W-1:0] x_in,
    input  logic [31:0]     offset,
    output logic [15:0]     x_bits,
    output logic            m,
    input  logic [31:0]     romout,
    output logic            busy,
    output logic [AW-1:0]   y,
    output logic            y_valid,
    input  logic            y_ready
);
    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  samp_q [16];
    logic [W-1:0]  samp_d [16];
    logic [31:0]   offset_q, offset_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          last;
    logic [AW-1:0] horner;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign horner = (acc_q << 1) + {{(AW-32){romout[31]}}, romout};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its sources, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)   state_d = RUN;
            RUN:     if (last)    state_d = HOLD;
            HOLD:    if (y_ready) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        start_rdy = (state_q == IDLE);
        busy      = (state_q == RUN) || (state_q == HOLD);
        y_valid   = (state_q == HOLD);
        m         = (state_q == RUN) && (cnt_q == '0);
        x_bits    = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < 16; i++) begin
                x_bits[i] = samp_q[i][W-1];
            end
        end
    end

    assign y = y_q;

    // NOTE: every variable gets its hold value first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        samp_d   = samp_q;
        offset_d = offset_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                samp_d[i] = x_in[i*W +: W];
            end
            offset_d = offset;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < 16; i++) begin
                samp_d[i] = samp_q[i] << 1;
            end
            acc_d = horner;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                y_d = horner + {{(AW-32){offset_q[31]}}, offset_q};
            end
        end
    end

    // NOTE: the sample registers are small flop arrays, not RAM, so they are cleared on
    // reset like all other state; an aborted frame leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                samp_q[i] <= '0;
            end
            offset_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
        end else begin
            samp_q   <= samp_d;
            offset_q <= offset_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
        end
    end

endmodule

// File: tb/tb_obc_dft_sequencer.sv
// Scoreboard bench for obc_dft_sequencer: expected results are computed as a weighted
// sum of ROM outputs over all bit-slices and compared when y_valid rises.
module tb_obc_dft_sequencer;
    localparam int W   = 16;
    localparam int AW  = 32 + W;
    localparam int TMO = 200;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic            start   = 1'b0;
    logic            start_rdy;
    logic [16*W-1:0] x_in    = '0;
    logic [31:0]     offset  = '0;
    logic [15:0]     x_bits;
    logic            m;
    logic [31:0]     romout;
    logic            busy;
    logic [AW-1:0]   y;
    logic            y_valid;
    logic            y_ready = 1'b1;

    int unsigned     rom_mode = 0;
    logic [16*32-1:0] coef    = '0;

    typedef struct {
        logic [AW-1:0] y;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   accepts[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic          prev_valid = 1'b0;
    logic          prev_hs    = 1'b0;
    logic [AW-1:0] prev_y     = '0;

    obc_dft_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_rdy (start_rdy),
        .x_in      (x_in),
        .offset    (offset),
        .x_bits    (x_bits),
        .m         (m),
        .romout    (romout),
        .busy      (busy),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM stubs: 0 constant, 1 sign of sample 0, 2 raw slice, 3 signed coefficient sum.
    function automatic logic [31:0] rom_fn(input int unsigned mode, input logic [15:0] xb,
                                           input logic mm, input logic [16*32-1:0] cf);
        logic [31:0] s;
        s = '0;
        case (mode)
            0: s = mm ? -32'sd5 : 32'sd5;
            1: s = mm ? -{31'd0, xb[0]} : {31'd0, xb[0]};
            2: s = {16'd0, xb};
            default: begin
                for (int i = 0; i < 16; i++) if (xb[i]) s = s + cf[i*32 +: 32];
                if (mm) s = -s;
            end
        endcase
        return s;
    endfunction

    assign romout = rom_fn(rom_mode, x_bits, m, coef);

    function automatic logic [15:0] slice_of(input logic [16*W-1:0] xs, input int j);
        logic [15:0] s;
        for (int i = 0; i < 16; i++) s[i] = xs[i*W + (W-1-j)];
        return s;
    endfunction

    // Result = sum over slices j of rom(slice_j) * 2^(W-1-j), plus offset, mod 2^AW.
    function automatic logic [AW-1:0] ref_y(input int unsigned mode, input logic [16*W-1:0] xs,
                                            input logic [31:0] off, input logic [16*32-1:0] cf);
        longint      sum;
        logic [31:0] r;
        sum = 0;
        for (int j = 0; j < W; j++) begin
            r   = rom_fn(mode, slice_of(xs, j), j == 0, cf);
            sum = sum + longint'($signed(r)) * (longint'(1) << (W-1-j));
        end
        sum = sum + longint'($signed(off));
        return sum[AW-1:0];
    endfunction

    function automatic logic [16*W-1:0] rand_xs();
        logic [16*W-1:0] xs;
        for (int i = 0; i < 16; i++) xs[i*W +: W] = W'($urandom);
        return xs;
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each rising y_valid, checks hold stability and release.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) begin
                check("release_valid_low", AW'(y_valid), AW'(0));
                check("release_idle", AW'(start_rdy), AW'(1));
            end
            if (y_valid && !prev_valid) begin
                check("result_was_expected", AW'(sb.size() > 0), AW'(1));
                if (sb.size() > 0) begin
                    e_cur = sb.pop_front();
                    check("y", y, e_cur.y);
                    check("valid_latency", AW'(cyc - e_cur.acc_cyc), AW'(W));
                end
                check("hold_busy", AW'(busy), AW'(1));
                check("hold_xbits_m", AW'({x_bits, m}), AW'(0));
            end
            if (y_valid && prev_valid) check("y_stable", y, prev_y);
            prev_valid = y_valid;
            prev_y     = y;
            prev_hs    = y_valid && y_ready;
        end
    end

    task automatic do_frame(input logic [16*W-1:0] xs, input logic [31:0] off,
                            input logic [AW-1:0] expy, input bit chk, input bit keep);
        int t;
        t = 0;
        @(negedge clk);
        while (!start_rdy && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("start_rdy_wait", AW'(start_rdy), AW'(1));
        x_in   = xs;
        offset = off;
        start  = 1'b1;
        sb.push_back('{y: expy, acc_cyc: cyc + 1});
        accepts.push_back(cyc + 1);
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
        x_in   = rand_xs();
        offset = $urandom;
        if (chk) begin
            for (int j = 0; j < W; j++) begin
                @(negedge clk);
                check("x_bits_slice", AW'(x_bits), AW'(slice_of(xs, j)));
                check("m_slice", AW'(m), AW'(j == 0));
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", AW'(sb.size()), AW'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_rdy"}, AW'(start_rdy), AW'(1));
        check({tag, "_busy"}, AW'(busy), AW'(0));
        check({tag, "_y_valid"}, AW'(y_valid), AW'(0));
        check({tag, "_y"}, y, AW'(0));
        check({tag, "_x_bits"}, AW'(x_bits), AW'(0));
        check({tag, "_m"}, AW'(m), AW'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*W-1:0] xs;
        logic [31:0]     off;
        int              t;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Constant ROM: -5*2^15 + 5*(2^15-1) = -5.
        rom_mode = 0;
        do_frame(rand_xs(), 32'd0, 48'hFFFF_FFFF_FFFB, 1'b0, 1'b0);
        drain();

        // Sign reconstruction through sample 0.
        rom_mode = 1;
        xs = rand_xs(); xs[0 +: W] = 16'h8003;
        do_frame(xs, 32'd0, 48'hFFFF_FFFF_8003, 1'b0, 1'b0);
        xs = rand_xs(); xs[0 +: W] = 16'h7FFF;
        do_frame(xs, 32'd0, 48'h0000_0000_7FFF, 1'b0, 1'b0);
        xs = rand_xs(); xs[0 +: W] = 16'h0001;
        do_frame(xs, 32'd100, 48'd101, 1'b0, 1'b0);
        drain();

        // Slice ordering: sample i = 1<<i gives a one-hot walking down from bit 15.
        rom_mode = 2;
        for (int i = 0; i < 16; i++) xs[i*W +: W] = W'(1) << i;
        do_frame(xs, 32'd0, ref_y(2, xs, 32'd0, coef), 1'b1, 1'b0);
        drain();

        // Random ROM coefficients, random samples and offsets.
        rom_mode = 3;
        for (int i = 0; i < 16; i++) coef[i*32 +: 32] = $urandom;
        for (int k = 0; k < 6; k++) begin
            xs  = rand_xs();
            off = $urandom;
            do_frame(xs, off, ref_y(3, xs, off, coef), k < 2, 1'b0);
        end
        drain();

        // Backpressure: hold y_ready low for 7 cycles with start pulses in between.
        y_ready = 1'b0;
        xs  = rand_xs();
        off = $urandom;
        do_frame(xs, off, ref_y(3, xs, off, coef), 1'b0, 1'b0);
        t = 0;
        while (!y_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", AW'(y_valid), AW'(1));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("bp_busy", AW'(busy), AW'(1));
            check("bp_valid_held", AW'(y_valid), AW'(1));
            start = (k % 2) == 0;
            x_in  = rand_xs();
        end
        @(negedge clk);
        y_ready = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("bp_idle_after_release", AW'(start_rdy), AW'(1));
        xs  = rand_xs();
        off = $urandom;
        do_frame(xs, off, ref_y(3, xs, off, coef), 1'b0, 1'b0);
        drain();

        // Reset mid-RUN at cnt=5: frame aborted, no result, then a clean frame.
        xs  = rand_xs();
        off = $urandom;
        do_frame(xs, off, ref_y(3, xs, off, coef), 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_valid", AW'(y_valid), AW'(0));
        xs  = rand_xs();
        off = $urandom;
        do_frame(xs, off, ref_y(3, xs, off, coef), 1'b1, 1'b0);
        drain();

        // Back-to-back: start held high, accepts must be W+2 cycles apart.
        accepts.delete();
        for (int k = 0; k < 8; k++) begin
            xs  = rand_xs();
            off = $urandom;
            do_frame(xs, off, ref_y(3, xs, off, coef), 1'b0, 1'b1);
        end
        start = 1'b0;
        drain();
        for (int k = 1; k < accepts.size(); k++) begin
            check("b2b_period", AW'(accepts[k] - accepts[k-1]), AW'(W + 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
